// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared fetch definitions: FSM state encoding, NOP word and default reset PC.
package pc_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_VALID = 2'd2,
    ST_TRAP  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory fetch bus: valid/ready request, single-cycle response pulse with no backpressure.
interface pc_fetch_ctrl_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );

endinterface

// File: rtl/pc_fetch_ctrl_fetch_timeout_ctr.sv
// Response-wait counter: o_expired flags the cycle in which the TIMEOUT_CYC-th enabled count lands.
// No latency beyond the count itself; TIMEOUT_CYC of 0 never expires.
module fetch_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned W = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  generate
    if (TIMEOUT_CYC == 0) begin : g_disabled
      logic w_unused;
      assign w_unused  = &r_cnt;
      assign o_expired = 1'b0;
    end else begin : g_enabled
      // Expiry is flagged while the final count is being taken, so the FSM traps on that same edge.
      assign o_expired = i_en && (r_cnt == W'(TIMEOUT_CYC - 1));
    end
  endgenerate

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC owner and instruction fetcher: one outstanding fetch, min 2 cycles REQ->instr_valid.
// Request stays asserted with stable address until accepted; halt only gates new requests.
import pc_fetch_ctrl_pkg::*;

module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = DEF_RESET_PC,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           i_next_pc,
  input  logic                  i_instr_ack,
  input  logic                  i_halt,
  pc_fetch_ctrl_if.master       imem,
  output logic [31:0]           o_pc,
  output logic [31:0]           o_instr,
  output logic                  o_instr_valid,
  output logic                  o_misalign_trap,
  output logic                  o_bus_err
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic         r_instr_vld;
  logic         r_req_vld;
  logic         r_misalign;
  logic         r_bus_err;

  logic w_req_hs;
  logic w_ctr_clr;
  logic w_ctr_en;
  logic w_expired;

  assign w_req_hs  = r_req_vld && imem.req_ready;
  assign w_ctr_clr = (r_state == ST_REQ) && w_req_hs;
  assign w_ctr_en  = (r_state == ST_WAIT) && !imem.rsp_valid;

  fetch_timeout_ctr #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_ctr_clr),
    .i_en      (w_ctr_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_REQ;
      r_pc        <= RESET_PC;
      r_instr     <= NOP_INSTR;
      r_instr_vld <= 1'b0;
      r_req_vld   <= 1'b0;
      r_misalign  <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_REQ: begin
          if (w_req_hs) begin
            r_req_vld <= 1'b0;
            r_state   <= ST_WAIT;
          end else begin
            r_req_vld <= r_req_vld || !i_halt;
          end
        end
        ST_WAIT: begin
          if (imem.rsp_valid) begin
            r_instr     <= imem.rsp_data;
            r_instr_vld <= 1'b1;
            r_state     <= ST_VALID;
          end else if (w_expired) begin
            r_bus_err <= 1'b1;
            r_state   <= ST_TRAP;
          end
        end
        ST_VALID: begin
          if (i_instr_ack) begin
            r_instr_vld <= 1'b0;
            if (is_word_aligned(i_next_pc)) begin
              r_pc      <= i_next_pc;
              // Raise the next request on the ack edge to save a cycle per instruction.
              r_req_vld <= !i_halt;
              r_state   <= ST_REQ;
            end else begin
              r_misalign <= 1'b1;
              r_state    <= ST_TRAP;
            end
          end
        end
        default: begin
          r_req_vld   <= 1'b0;
          r_instr_vld <= 1'b0;
        end
      endcase
    end
  end

  assign imem.req_valid  = r_req_vld;
  assign imem.req_addr   = r_pc;
  assign o_pc            = r_pc;
  assign o_instr         = r_instr;
  assign o_instr_valid   = r_instr_vld;
  assign o_misalign_trap = r_misalign;
  assign o_bus_err       = r_bus_err;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: cycle table for the main fetch flow plus hand sequences for traps and reset.
module tb_pc_fetch_ctrl;
  import pc_fetch_ctrl_pkg::*;

  typedef struct packed {
    logic        req_vld;
    logic [31:0] addr;
    logic [31:0] pc;
    logic        iv;
    logic [31:0] instr;
    logic        trap;
    logic        err;
  } obs_t;

  typedef struct {
    logic        halt;
    logic        ready;
    logic        rsp;
    logic [31:0] rsp_dat;
    logic        ack;
    logic [31:0] npc;
    obs_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] next_pc;
  logic        instr_ack;
  logic        halt;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        misalign_trap;
  logic        bus_err;

  int n_cmp = 0;
  int n_err = 0;

  pc_fetch_ctrl_if imem_if ();

  pc_fetch_ctrl #(
    .RESET_PC    (32'h0000_0000),
    .TIMEOUT_CYC (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_next_pc       (next_pc),
    .i_instr_ack     (instr_ack),
    .i_halt          (halt),
    .imem            (imem_if),
    .o_pc            (pc),
    .o_instr         (instr),
    .o_instr_valid   (instr_valid),
    .o_misalign_trap (misalign_trap),
    .o_bus_err       (bus_err)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input logic rv, input logic [31:0] a, input logic [31:0] p,
                              input logic v, input logic [31:0] i, input logic t, input logic e);
    obs_t o;
    o.req_vld = rv; o.addr = a; o.pc = p; o.iv = v; o.instr = i; o.trap = t; o.err = e;
    return o;
  endfunction

  function automatic obs_t sample();
    return mk(imem_if.req_valid, imem_if.req_addr, pc, instr_valid, instr, misalign_trap, bus_err);
  endfunction

  task automatic check(input string name, input obs_t exp);
    obs_t act;
    act = sample();
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got req=%b addr=%h pc=%h iv=%b instr=%h trap=%b err=%b / want req=%b addr=%h pc=%h iv=%b instr=%h trap=%b err=%b",
               name, act.req_vld, act.addr, act.pc, act.iv, act.instr, act.trap, act.err,
               exp.req_vld, exp.addr, exp.pc, exp.iv, exp.instr, exp.trap, exp.err);
    end
  endtask

  task automatic drive(input logic h, input logic r, input logic s, input logic [31:0] d,
                       input logic a, input logic [31:0] n);
    halt = h; imem_if.req_ready = r; imem_if.rsp_valid = s; imem_if.rsp_data = d;
    instr_ack = a; next_pc = n;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 32'h0, 0, 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  vec_t vecs[16];

  initial begin
    // halt ready rsp rsp_dat ack next_pc ; expected after the edge
    vecs[0]  = '{0,0,0,32'h0,        0,32'h0,        mk(1,32'h0,32'h0,0,NOP_INSTR,0,0)};
    vecs[1]  = '{0,1,0,32'h0,        0,32'h0,        mk(0,32'h0,32'h0,0,NOP_INSTR,0,0)};
    vecs[2]  = '{0,0,1,32'h00500093, 0,32'h0,        mk(0,32'h0,32'h0,1,32'h00500093,0,0)};
    vecs[3]  = '{0,0,1,32'hDEADBEEF, 0,32'h0,        mk(0,32'h0,32'h0,1,32'h00500093,0,0)};
    vecs[4]  = '{0,0,0,32'h0,        1,32'h4,        mk(1,32'h4,32'h4,0,32'h00500093,0,0)};
    vecs[5]  = '{0,0,0,32'h0,        1,32'h100,      mk(1,32'h4,32'h4,0,32'h00500093,0,0)};
    vecs[6]  = '{1,0,0,32'h0,        0,32'h0,        mk(1,32'h4,32'h4,0,32'h00500093,0,0)};
    vecs[7]  = '{1,0,0,32'h0,        0,32'h0,        mk(1,32'h4,32'h4,0,32'h00500093,0,0)};
    vecs[8]  = '{1,1,0,32'h0,        0,32'h0,        mk(0,32'h4,32'h4,0,32'h00500093,0,0)};
    vecs[9]  = '{0,0,1,32'h00a00113, 1,32'h8,        mk(0,32'h4,32'h4,1,32'h00a00113,0,0)};
    vecs[10] = '{1,0,0,32'h0,        1,32'hFFFF_FFFC,mk(0,32'hFFFF_FFFC,32'hFFFF_FFFC,0,32'h00a00113,0,0)};
    vecs[11] = '{1,1,1,32'hCAFEF00D, 0,32'h0,        mk(0,32'hFFFF_FFFC,32'hFFFF_FFFC,0,32'h00a00113,0,0)};
    vecs[12] = '{0,1,0,32'h0,        0,32'h0,        mk(1,32'hFFFF_FFFC,32'hFFFF_FFFC,0,32'h00a00113,0,0)};
    vecs[13] = '{0,1,0,32'h0,        0,32'h0,        mk(0,32'hFFFF_FFFC,32'hFFFF_FFFC,0,32'h00a00113,0,0)};
    vecs[14] = '{0,0,1,32'h0000006f, 0,32'h0,        mk(0,32'hFFFF_FFFC,32'hFFFF_FFFC,1,32'h0000006f,0,0)};
    vecs[15] = '{0,0,0,32'h0,        1,32'h0,        mk(1,32'h0,32'h0,0,32'h0000006f,0,0)};

    drive(0, 0, 0, 32'h0, 0, 32'h0);
    rst = 1'b1;
    #12;
    check("reset_state", mk(0, 32'h0, 32'h0, 0, NOP_INSTR, 0, 0));
    step();
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].halt, vecs[i].ready, vecs[i].rsp, vecs[i].rsp_dat, vecs[i].ack, vecs[i].npc);
      step();
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Misaligned next_pc traps, keeps pc and never requests again.
    do_reset();
    drive(0, 0, 0, 32'h0, 0, 32'h0);            step();
    drive(0, 1, 0, 32'h0, 0, 32'h0);            step();
    drive(0, 0, 1, 32'h00000013, 0, 32'h0);     step();
    drive(0, 0, 0, 32'h0, 1, 32'h0000_0102);    step();
    check("misalign_trap", mk(0, 32'h0, 32'h0, 0, 32'h00000013, 1, 0));
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 32'h12345678, 1, 32'h8);   step();
      check($sformatf("misalign_hold%0d", i), mk(0, 32'h0, 32'h0, 0, 32'h00000013, 1, 0));
    end

    // Response timeout after exactly 4 WAIT cycles; late response ignored.
    do_reset();
    drive(0, 0, 0, 32'h0, 0, 32'h0);            step();
    drive(0, 1, 0, 32'h0, 0, 32'h0);            step();
    drive(0, 0, 0, 32'h0, 0, 32'h0);
    step(); step(); step();
    check("timeout_wait3", mk(0, 32'h0, 32'h0, 0, NOP_INSTR, 0, 0));
    step();
    check("timeout_wait4", mk(0, 32'h0, 32'h0, 0, NOP_INSTR, 0, 1));
    drive(0, 1, 1, 32'h00000055, 0, 32'h0);     step();
    drive(0, 1, 0, 32'h0, 0, 32'h0);            step();
    check("timeout_late_rsp", mk(0, 32'h0, 32'h0, 0, NOP_INSTR, 0, 1));

    // Async reset while waiting at 0x40; the stale response must not land.
    do_reset();
    drive(0, 0, 0, 32'h0, 0, 32'h0);            step();
    drive(0, 1, 0, 32'h0, 0, 32'h0);            step();
    drive(0, 0, 1, 32'h00000011, 0, 32'h0);     step();
    drive(0, 0, 0, 32'h0, 1, 32'h40);           step();
    check("pre_reset_req", mk(1, 32'h40, 32'h40, 0, 32'h00000011, 0, 0));
    drive(0, 1, 0, 32'h0, 0, 32'h0);            step();
    drive(0, 0, 0, 32'h0, 0, 32'h0);            step();
    #2 rst = 1'b1;
    #1;
    check("async_reset_in_wait", mk(0, 32'h0, 32'h0, 0, NOP_INSTR, 0, 0));
    step();
    rst = 1'b0;
    drive(0, 0, 1, 32'h00000077, 0, 32'h0);     step();
    check("rsp_after_reset", mk(1, 32'h0, 32'h0, 0, NOP_INSTR, 0, 0));
    drive(0, 0, 0, 32'h0, 0, 32'h0);            step();
    check("reissue_at_reset_pc", mk(1, 32'h0, 32'h0, 0, NOP_INSTR, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
